// File: rtl/cluster_addr_demux_if.sv
// AXI4 bus bundle shared by the cluster address demultiplexer and its neighbours.
// The master modport drives requests; the slave modport answers them.
interface cluster_addr_demux_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_USER_WIDTH = 6
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_qos;
   logic [3:0]                  aw_region;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_qos;
   logic [3:0]                  ar_region;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/cluster_addr_demux.sv
// One-to-NB_MST AXI4 address demultiplexer with cluster-relative windows,
// in-order response tracking per direction and an internal DECERR responder.
module cluster_addr_demux #(
   parameter int unsigned          NB_MST         = 4,
   parameter int unsigned          AXI_ADDR_WIDTH = 64,
   parameter int unsigned          AXI_DATA_WIDTH = 64,
   parameter int unsigned          AXI_ID_WIDTH   = 4,
   parameter int unsigned          AXI_USER_WIDTH = 6,
   parameter logic [63:0]          BASE_ADDR      = 64'h1000_0000,
   parameter int unsigned          CLUSTER_SHIFT  = 22,
   parameter logic [NB_MST*64-1:0] WIN_OFFS       = '0,
   parameter logic [NB_MST*64-1:0] WIN_SIZE       = '0,
   parameter int unsigned          MAX_TXNS       = 8,
   parameter logic [63:0]          ERR_DATA       = 64'hBADC_AB1E_BADC_AB1E
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [5:0]                  cluster_id_i,
   cluster_addr_demux_if.slave         slv,
   cluster_addr_demux_if.master        mst [NB_MST],
   output logic                        busy_o,
   output logic [15:0]                 decerr_cnt_o
);
   localparam int unsigned TGT_W = $clog2(NB_MST + 1);
   localparam int unsigned CNT_W = $clog2(MAX_TXNS + 1);
   localparam int unsigned PTR_W = (MAX_TXNS > 1) ? $clog2(MAX_TXNS) : 1;
   localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NB_MST);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TXNS);

   localparam logic [1:0] EW_IDLE = 2'd0;
   localparam logic [1:0] EW_DATA = 2'd1;
   localparam logic [1:0] EW_RESP = 2'd2;
   localparam logic [0:0] ER_IDLE = 1'b0;
   localparam logic [0:0] ER_DATA = 1'b1;

   // Lowest matching window wins; zero-sized windows never match.
   function automatic logic [TGT_W-1:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                input logic [AXI_ADDR_WIDTH-1:0] base);
      logic [TGT_W-1:0]          tgt;
      logic [AXI_ADDR_WIDTH-1:0] lo;
      logic [AXI_ADDR_WIDTH-1:0] hi;
      tgt = ERR_TGT;
      for (int i = NB_MST - 1; i >= 0; i--) begin
         lo = base + AXI_ADDR_WIDTH'(WIN_OFFS[i*64 +: 64]);
         hi = lo + AXI_ADDR_WIDTH'(WIN_SIZE[i*64 +: 64]);
         if ((WIN_SIZE[i*64 +: 64] != 64'd0) && (addr >= lo) && (addr < hi)) tgt = TGT_W'(i);
      end
      return tgt;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
      case ({inc, dec})
         2'b10:   return cnt + CNT_W'(1);
         2'b01:   return cnt - CNT_W'(1);
         default: return cnt;
      endcase
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, acc} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic [AXI_ADDR_WIDTH-1:0] base;
   logic [TGT_W-1:0]          aw_tgt, ar_tgt, w_tgt, wr_cur, rd_cur;
   logic [CNT_W-1:0]          wr_cnt, rd_cnt, fifo_cnt;
   logic [PTR_W-1:0]          wptr, rptr;
   logic [TGT_W-1:0]          fifo_mem [2**PTR_W];
   logic                      aw_ok, ar_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                      w_avail, wr_busy, rd_busy, dec_b, dec_r;
   logic [1:0]                ew_state;
   logic [0:0]                er_state;
   logic [AXI_ID_WIDTH-1:0]   ew_id, er_id;
   logic [7:0]                er_len, er_beat;

   // Index NB_MST of every per-target vector is the DECERR responder.
   logic [NB_MST:0]           aw_rdy_v, w_rdy_v, b_vld_v, ar_rdy_v, r_vld_v, r_last_v;
   logic [AXI_ID_WIDTH-1:0]   b_id_v   [NB_MST+1];
   logic [1:0]                b_resp_v [NB_MST+1];
   logic [AXI_USER_WIDTH-1:0] b_user_v [NB_MST+1];
   logic [AXI_ID_WIDTH-1:0]   r_id_v   [NB_MST+1];
   logic [AXI_DATA_WIDTH-1:0] r_data_v [NB_MST+1];
   logic [1:0]                r_resp_v [NB_MST+1];
   logic [AXI_USER_WIDTH-1:0] r_user_v [NB_MST+1];

   assign base   = AXI_ADDR_WIDTH'(BASE_ADDR + (64'(cluster_id_i) << CLUSTER_SHIFT));
   assign aw_tgt = decode(slv.aw_addr, base);
   assign ar_tgt = decode(slv.ar_addr, base);

   assign wr_busy = (wr_cnt != '0);
   assign rd_busy = (rd_cnt != '0);
   assign busy_o  = wr_busy | rd_busy;

   // A target switch waits for the direction to drain so responses stay ordered.
   assign aw_ok = rst_ni & (!wr_busy | ((aw_tgt == wr_cur) & (wr_cnt < MAX_CNT)));
   assign ar_ok = rst_ni & (!rd_busy | ((ar_tgt == rd_cur) & (rd_cnt < MAX_CNT)));

   assign slv.aw_ready = aw_ok & aw_rdy_v[aw_tgt];
   assign slv.ar_ready = ar_ok & ar_rdy_v[ar_tgt];
   assign aw_hs        = slv.aw_valid & slv.aw_ready;
   assign ar_hs        = slv.ar_valid & slv.ar_ready;

   // W follows the oldest write whose data is still owed; bypass when the queue is empty.
   assign w_tgt       = (fifo_cnt == '0) ? aw_tgt : fifo_mem[rptr];
   assign w_avail     = (fifo_cnt != '0) | aw_hs;
   assign slv.w_ready = w_avail & w_rdy_v[w_tgt];
   assign w_hs        = slv.w_valid & slv.w_ready;

   assign slv.b_valid = wr_busy & b_vld_v[wr_cur];
   assign slv.b_id    = b_id_v[wr_cur];
   assign slv.b_resp  = b_resp_v[wr_cur];
   assign slv.b_user  = b_user_v[wr_cur];
   assign b_hs        = slv.b_valid & slv.b_ready;

   assign slv.r_valid = rd_busy & r_vld_v[rd_cur];
   assign slv.r_id    = r_id_v[rd_cur];
   assign slv.r_data  = r_data_v[rd_cur];
   assign slv.r_resp  = r_resp_v[rd_cur];
   assign slv.r_last  = r_last_v[rd_cur];
   assign slv.r_user  = r_user_v[rd_cur];
   assign r_hs        = slv.r_valid & slv.r_ready;

   assign dec_b = b_hs & (wr_cur == ERR_TGT);
   assign dec_r = r_hs & slv.r_last & (rd_cur == ERR_TGT);

   for (genvar i = 0; i < NB_MST; i++) begin : g_mst
      assign mst[i].aw_id     = slv.aw_id;
      assign mst[i].aw_addr   = slv.aw_addr;
      assign mst[i].aw_len    = slv.aw_len;
      assign mst[i].aw_size   = slv.aw_size;
      assign mst[i].aw_burst  = slv.aw_burst;
      assign mst[i].aw_lock   = slv.aw_lock;
      assign mst[i].aw_cache  = slv.aw_cache;
      assign mst[i].aw_prot   = slv.aw_prot;
      assign mst[i].aw_qos    = slv.aw_qos;
      assign mst[i].aw_region = slv.aw_region;
      assign mst[i].aw_user   = slv.aw_user;
      assign mst[i].aw_valid  = slv.aw_valid & aw_ok & (aw_tgt == TGT_W'(i));
      assign mst[i].w_data    = slv.w_data;
      assign mst[i].w_strb    = slv.w_strb;
      assign mst[i].w_last    = slv.w_last;
      assign mst[i].w_user    = slv.w_user;
      assign mst[i].w_valid   = slv.w_valid & w_avail & (w_tgt == TGT_W'(i));
      assign mst[i].b_ready   = slv.b_ready & wr_busy & (wr_cur == TGT_W'(i));
      assign mst[i].ar_id     = slv.ar_id;
      assign mst[i].ar_addr   = slv.ar_addr;
      assign mst[i].ar_len    = slv.ar_len;
      assign mst[i].ar_size   = slv.ar_size;
      assign mst[i].ar_burst  = slv.ar_burst;
      assign mst[i].ar_lock   = slv.ar_lock;
      assign mst[i].ar_cache  = slv.ar_cache;
      assign mst[i].ar_prot   = slv.ar_prot;
      assign mst[i].ar_qos    = slv.ar_qos;
      assign mst[i].ar_region = slv.ar_region;
      assign mst[i].ar_user   = slv.ar_user;
      assign mst[i].ar_valid  = slv.ar_valid & ar_ok & (ar_tgt == TGT_W'(i));
      assign mst[i].r_ready   = slv.r_ready & rd_busy & (rd_cur == TGT_W'(i));

      assign aw_rdy_v[i] = mst[i].aw_ready;
      assign w_rdy_v[i]  = mst[i].w_ready;
      assign b_vld_v[i]  = mst[i].b_valid;
      assign b_id_v[i]   = mst[i].b_id;
      assign b_resp_v[i] = mst[i].b_resp;
      assign b_user_v[i] = mst[i].b_user;
      assign ar_rdy_v[i] = mst[i].ar_ready;
      assign r_vld_v[i]  = mst[i].r_valid;
      assign r_last_v[i] = mst[i].r_last;
      assign r_id_v[i]   = mst[i].r_id;
      assign r_data_v[i] = mst[i].r_data;
      assign r_resp_v[i] = mst[i].r_resp;
      assign r_user_v[i] = mst[i].r_user;
   end

   assign aw_rdy_v[NB_MST] = (ew_state == EW_IDLE);
   assign w_rdy_v[NB_MST]  = (ew_state == EW_DATA);
   assign b_vld_v[NB_MST]  = (ew_state == EW_RESP);
   assign b_id_v[NB_MST]   = ew_id;
   assign b_resp_v[NB_MST] = 2'b11;
   assign b_user_v[NB_MST] = '0;
   assign ar_rdy_v[NB_MST] = (er_state == ER_IDLE);
   assign r_vld_v[NB_MST]  = (er_state == ER_DATA);
   assign r_last_v[NB_MST] = (er_beat == er_len);
   assign r_id_v[NB_MST]   = er_id;
   assign r_data_v[NB_MST] = AXI_DATA_WIDTH'(ERR_DATA);
   assign r_resp_v[NB_MST] = 2'b11;
   assign r_user_v[NB_MST] = '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_cnt       <= '0;
         rd_cnt       <= '0;
         wr_cur       <= '0;
         rd_cur       <= '0;
         fifo_cnt     <= '0;
         wptr         <= '0;
         rptr         <= '0;
         ew_state     <= EW_IDLE;
         er_state     <= ER_IDLE;
         er_beat      <= '0;
         decerr_cnt_o <= '0;
      end else begin
         wr_cnt   <= cnt_next(wr_cnt, aw_hs, b_hs);
         rd_cnt   <= cnt_next(rd_cnt, ar_hs, r_hs & slv.r_last);
         fifo_cnt <= cnt_next(fifo_cnt, aw_hs, w_hs & slv.w_last);
         if (aw_hs) wr_cur <= aw_tgt;
         if (ar_hs) rd_cur <= ar_tgt;
         if (aw_hs) wptr <= wptr + PTR_W'(1);
         if (w_hs && slv.w_last) rptr <= rptr + PTR_W'(1);
         decerr_cnt_o <= sat_add(decerr_cnt_o, {1'b0, dec_b} + {1'b0, dec_r});

         case (ew_state)
            EW_IDLE: if (aw_hs && aw_tgt == ERR_TGT) ew_state <= EW_DATA;
            EW_DATA: if (w_hs && w_tgt == ERR_TGT && slv.w_last) ew_state <= EW_RESP;
            EW_RESP: if (dec_b) ew_state <= EW_IDLE;
            default: ew_state <= EW_IDLE;
         endcase

         if (ar_hs && ar_tgt == ERR_TGT) begin
            er_state <= ER_DATA;
            er_beat  <= '0;
         end else if (r_hs && rd_cur == ERR_TGT) begin
            if (slv.r_last) er_state <= ER_IDLE;
            else            er_beat  <= er_beat + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (aw_hs) fifo_mem[wptr] <= aw_tgt;
      if (aw_hs && aw_tgt == ERR_TGT) ew_id <= slv.aw_id;
      if (ar_hs && ar_tgt == ERR_TGT) begin
         er_id  <= slv.ar_id;
         er_len <= slv.ar_len;
      end
   end
endmodule

// File: tb/tb_cluster_addr_demux.sv
// Directed bench for cluster_addr_demux: routing, overlap priority, DECERR responder,
// outstanding limit, target-switch stall and mid-burst reset.
module tb_cluster_addr_demux;
   localparam logic [63:0] ERR_D = 64'hBADC_AB1E_BADC_AB1E;

   logic        clk;
   logic        rst_n;
   logic [5:0]  cid;
   logic        busy;
   logic [15:0] decerr;
   int          total;
   int          bad;

   wire  [3:0]  m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
   logic [3:0]  m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
   logic [3:0]  m_b_id, m_r_id;
   logic [1:0]  m_b_resp, m_r_resp;
   logic [63:0] m_r_data;
   logic        m_r_last;

   cluster_addr_demux_if slv_if ();
   cluster_addr_demux_if mst_if [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_m
      assign m_aw_valid[g]     = mst_if[g].aw_valid;
      assign m_w_valid[g]      = mst_if[g].w_valid;
      assign m_b_ready[g]      = mst_if[g].b_ready;
      assign m_ar_valid[g]     = mst_if[g].ar_valid;
      assign m_r_ready[g]      = mst_if[g].r_ready;
      assign mst_if[g].aw_ready = m_aw_ready[g];
      assign mst_if[g].w_ready  = m_w_ready[g];
      assign mst_if[g].b_valid  = m_b_valid[g];
      assign mst_if[g].b_id     = m_b_id;
      assign mst_if[g].b_resp   = m_b_resp;
      assign mst_if[g].b_user   = 6'd0;
      assign mst_if[g].ar_ready = m_ar_ready[g];
      assign mst_if[g].r_valid  = m_r_valid[g];
      assign mst_if[g].r_id     = m_r_id;
      assign mst_if[g].r_data   = m_r_data;
      assign mst_if[g].r_resp   = m_r_resp;
      assign mst_if[g].r_last   = m_r_last;
      assign mst_if[g].r_user   = 6'd0;
   end

   cluster_addr_demux #(
      .NB_MST   (4),
      .WIN_OFFS ({64'h80_0000, 64'h40_0100, 64'h40_0000, 64'h0}),
      .WIN_SIZE ({64'h0,       64'h1000,    64'h1000,    64'h10000}),
      .MAX_TXNS (8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cluster_id_i (cid),
      .slv          (slv_if),
      .mst          (mst_if),
      .busy_o       (busy),
      .decerr_cnt_o (decerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      cid   = 6'd3;
      m_aw_ready = '0; m_w_ready = '0; m_b_valid = '0; m_ar_ready = '0; m_r_valid = '0;
      m_b_id = '0; m_b_resp = '0; m_r_id = '0; m_r_resp = '0; m_r_data = '0; m_r_last = 1'b0;
      slv_if.aw_id = '0; slv_if.aw_addr = '0; slv_if.aw_len = '0; slv_if.aw_size = 3'd3;
      slv_if.aw_burst = 2'b01; slv_if.aw_lock = 1'b0; slv_if.aw_cache = '0; slv_if.aw_prot = '0;
      slv_if.aw_qos = '0; slv_if.aw_region = '0; slv_if.aw_user = '0;
      slv_if.w_data = '0; slv_if.w_strb = '1; slv_if.w_last = 1'b0; slv_if.w_user = '0;
      slv_if.w_valid = 1'b0; slv_if.b_ready = 1'b0;
      slv_if.ar_id = '0; slv_if.ar_addr = '0; slv_if.ar_len = '0; slv_if.ar_size = 3'd3;
      slv_if.ar_burst = 2'b01; slv_if.ar_lock = 1'b0; slv_if.ar_cache = '0; slv_if.ar_prot = '0;
      slv_if.ar_qos = '0; slv_if.ar_region = '0; slv_if.ar_user = '0;
      slv_if.ar_valid = 1'b0; slv_if.r_ready = 1'b0;
      // An AW presented during reset must not leak to any master.
      slv_if.aw_valid = 1'b1;
      slv_if.aw_addr  = 64'h10C0_0000;
      m_aw_ready      = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_decerr", 64'(decerr), 64'h0);
      chk("rst_aw_ready", 64'(slv_if.aw_ready), 64'h0);
      chk("rst_m_aw_valid", 64'(m_aw_valid), 64'h0);
      chk("rst_b_valid", 64'(slv_if.b_valid), 64'h0);
      chk("rst_r_valid", 64'(slv_if.r_valid), 64'h0);
      slv_if.aw_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // Read at 0x10C0_0040 with cluster 3 -> window 0.
      slv_if.ar_valid = 1'b1; slv_if.ar_addr = 64'h10C0_0040; slv_if.ar_id = 4'h5;
      slv_if.ar_len = 8'd0; m_ar_ready = 4'hF;
      #1;
      chk("t1_ar_route", 64'(m_ar_valid), 64'h1);
      chk("t1_ar_ready", 64'(slv_if.ar_ready), 64'h1);
      step();
      slv_if.ar_valid = 1'b0;
      #1 chk("t1_busy_hi", 64'(busy), 64'h1);
      m_r_valid = 4'b0001; m_r_data = 64'h1122_3344_5566_7788; m_r_id = 4'h5;
      m_r_last = 1'b1; m_r_resp = 2'b00; slv_if.r_ready = 1'b1;
      #1;
      chk("t1_r_valid", 64'(slv_if.r_valid), 64'h1);
      chk("t1_r_data", slv_if.r_data, 64'h1122_3344_5566_7788);
      chk("t1_r_id", 64'(slv_if.r_id), 64'h5);
      chk("t1_m_r_ready", 64'(m_r_ready), 64'h1);
      step();
      m_r_valid = '0; slv_if.r_ready = 1'b0;
      #1 chk("t1_busy_lo", 64'(busy), 64'h0);

      // Cluster 2: windows 1 and 2 both cover 0x10C0_0200; window 1 wins.
      cid = 6'd2;
      slv_if.aw_valid = 1'b1; slv_if.aw_addr = 64'h10C0_0200; slv_if.aw_id = 4'h3;
      slv_if.aw_len = 8'd0; slv_if.w_valid = 1'b1; slv_if.w_last = 1'b1;
      m_aw_ready = 4'hF; m_w_ready = 4'hF;
      #1;
      chk("t2_aw_route", 64'(m_aw_valid), 64'h2);
      chk("t2_aw_ready", 64'(slv_if.aw_ready), 64'h1);
      chk("t2_w_bypass", 64'(m_w_valid), 64'h2);
      chk("t2_w_ready", 64'(slv_if.w_ready), 64'h1);
      step();
      slv_if.aw_valid = 1'b0; slv_if.w_valid = 1'b0;
      m_b_valid = 4'b0010; m_b_id = 4'h3; m_b_resp = 2'b00; slv_if.b_ready = 1'b1;
      #1;
      chk("t2_b_valid", 64'(slv_if.b_valid), 64'h1);
      chk("t2_b_id", 64'(slv_if.b_id), 64'h3);
      chk("t2_m_b_ready", 64'(m_b_ready), 64'h2);
      step();
      m_b_valid = '0; slv_if.b_ready = 1'b0;
      #1 chk("t2_busy_lo", 64'(busy), 64'h0);
      cid = 6'd3;

      // Unmapped write, len 3: four beats sunk then DECERR with echoed ID.
      slv_if.aw_valid = 1'b1; slv_if.aw_addr = 64'h8000_0000; slv_if.aw_id = 4'hA;
      slv_if.aw_len = 8'd3; slv_if.w_valid = 1'b1; slv_if.w_last = 1'b0;
      #1;
      chk("t3_aw_no_mst", 64'(m_aw_valid), 64'h0);
      chk("t3_aw_ready", 64'(slv_if.aw_ready), 64'h1);
      chk("t3_w_wait", 64'(slv_if.w_ready), 64'h0);
      step();
      slv_if.aw_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         slv_if.w_last = (k == 3);
         #1;
         chk("t3_w_sink", 64'(slv_if.w_ready), 64'h1);
         chk("t3_w_no_mst", 64'(m_w_valid), 64'h0);
         step();
      end
      slv_if.w_valid = 1'b0; slv_if.w_last = 1'b0; slv_if.b_ready = 1'b1;
      #1;
      chk("t3_b_valid", 64'(slv_if.b_valid), 64'h1);
      chk("t3_b_resp", 64'(slv_if.b_resp), 64'h3);
      chk("t3_b_id", 64'(slv_if.b_id), 64'hA);
      step();
      slv_if.b_ready = 1'b0;
      #1;
      chk("t3_decerr_1", 64'(decerr), 64'h1);
      chk("t3_busy_lo", 64'(busy), 64'h0);

      // Unmapped read, len 7: eight ERR_DATA beats, one cycle of backpressure first.
      slv_if.ar_valid = 1'b1; slv_if.ar_addr = 64'h8000_0000; slv_if.ar_id = 4'h6;
      slv_if.ar_len = 8'd7;
      #1 chk("t3_ar_ready", 64'(slv_if.ar_ready), 64'h1);
      step();
      slv_if.ar_valid = 1'b0;
      #1;
      chk("t3_r_held", 64'(slv_if.r_valid), 64'h1);
      chk("t3_r_resp", 64'(slv_if.r_resp), 64'h3);
      chk("t3_r_id", 64'(slv_if.r_id), 64'h6);
      step();
      slv_if.r_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t3_r_data", slv_if.r_data, ERR_D);
         chk("t3_r_last", 64'(slv_if.r_last), (k == 7) ? 64'h1 : 64'h0);
         step();
      end
      slv_if.r_ready = 1'b0;
      #1;
      chk("t3_decerr_2", 64'(decerr), 64'h2);
      chk("t3_busy_rd", 64'(busy), 64'h0);

      // Eight reads outstanding to mst[0]; the ninth stalls until one rlast.
      m_ar_ready = 4'hF; m_r_valid = '0; slv_if.ar_len = 8'd0;
      for (int k = 0; k < 8; k++) begin
         slv_if.ar_valid = 1'b1; slv_if.ar_addr = 64'h10C0_0000 + 64'(k * 64);
         slv_if.ar_id = 4'(k);
         #1 chk("t4_ar_accept", 64'(slv_if.ar_ready), 64'h1);
         step();
      end
      slv_if.ar_addr = 64'h10C0_0400;
      #1;
      chk("t4_ar_stall", 64'(slv_if.ar_ready), 64'h0);
      chk("t4_m_ar_stall", 64'(m_ar_valid), 64'h0);
      step();
      m_r_valid = 4'b0001; m_r_last = 1'b1; slv_if.r_ready = 1'b1;
      #1 chk("t4_ar_stall_r", 64'(slv_if.ar_ready), 64'h0);
      step();
      m_r_valid = '0;
      #1;
      chk("t4_ar_resume", 64'(slv_if.ar_ready), 64'h1);
      chk("t4_m_ar_resume", 64'(m_ar_valid), 64'h1);
      step();
      slv_if.ar_valid = 1'b0; m_r_valid = 4'b0001;
      repeat (8) step();
      m_r_valid = '0; slv_if.r_ready = 1'b0;
      #1 chk("t4_busy_lo", 64'(busy), 64'h0);

      // Write to mst[0] outstanding; a write to mst[1] waits for its B.
      m_aw_ready = 4'hF; m_w_ready = 4'hF;
      slv_if.aw_valid = 1'b1; slv_if.aw_addr = 64'h10C0_0000; slv_if.aw_id = 4'h1;
      slv_if.aw_len = 8'd0; slv_if.w_valid = 1'b1; slv_if.w_last = 1'b1;
      #1 chk("t5_aw0_route", 64'(m_aw_valid), 64'h1);
      step();
      slv_if.aw_addr = 64'h1100_0000; slv_if.aw_id = 4'h2;
      #1;
      chk("t5_aw1_stall", 64'(slv_if.aw_ready), 64'h0);
      chk("t5_m_aw_stall", 64'(m_aw_valid), 64'h0);
      chk("t5_w_held", 64'(m_w_valid), 64'h0);
      step();
      m_b_valid = 4'b0001; m_b_id = 4'h1; slv_if.b_ready = 1'b1;
      #1;
      chk("t5_aw1_stall_b", 64'(slv_if.aw_ready), 64'h0);
      chk("t5_b0_id", 64'(slv_if.b_id), 64'h1);
      step();
      m_b_valid = '0;
      #1;
      chk("t5_aw1_fwd", 64'(m_aw_valid), 64'h2);
      chk("t5_aw1_ready", 64'(slv_if.aw_ready), 64'h1);
      chk("t5_w1_route", 64'(m_w_valid), 64'h2);
      step();
      slv_if.aw_valid = 1'b0; slv_if.w_valid = 1'b0;
      m_b_valid = 4'b0010; m_b_id = 4'h2;
      #1 chk("t5_b1_id", 64'(slv_if.b_id), 64'h2);
      step();
      m_b_valid = '0; slv_if.b_ready = 1'b0;
      #1 chk("t5_busy_lo", 64'(busy), 64'h0);

      // DECERR read via the disabled window 3, reset after two beats.
      slv_if.ar_valid = 1'b1; slv_if.ar_addr = 64'h1140_0000; slv_if.ar_id = 4'h7;
      slv_if.ar_len = 8'd3;
      #1;
      chk("t6_ar_no_mst", 64'(m_ar_valid), 64'h0);
      chk("t6_ar_ready", 64'(slv_if.ar_ready), 64'h1);
      step();
      slv_if.ar_valid = 1'b0; slv_if.r_ready = 1'b1;
      repeat (2) step();
      #1 chk("t6_r_beat3", 64'(slv_if.r_valid), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_r_valid", 64'(slv_if.r_valid), 64'h0);
      chk("t6_rst_decerr", 64'(decerr), 64'h0);
      chk("t6_rst_busy", 64'(busy), 64'h0);
      step();
      rst_n = 1'b1;
      slv_if.ar_valid = 1'b1; slv_if.ar_addr = 64'h10C0_0080; slv_if.ar_id = 4'h9;
      slv_if.ar_len = 8'd0;
      #1 chk("t6_fresh_route", 64'(m_ar_valid), 64'h1);
      step();
      slv_if.ar_valid = 1'b0;
      m_r_valid = 4'b0001; m_r_data = 64'hCAFE_0000_F00D_0001; m_r_id = 4'h9; m_r_last = 1'b1;
      #1;
      chk("t6_fresh_data", slv_if.r_data, 64'hCAFE_0000_F00D_0001);
      chk("t6_fresh_last", 64'(slv_if.r_last), 64'h1);
      step();
      m_r_valid = '0; slv_if.r_ready = 1'b0;
      #1;
      chk("t6_fresh_busy", 64'(busy), 64'h0);
      chk("t6_fresh_decerr", 64'(decerr), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cluster_addr_demux.md
Name: cluster_addr_demux

Overview:
- Parametrised single-slave-port to NB_MST-master-port AXI4 address demultiplexer for the cluster bus.
- Address windows are relocated at runtime by cluster_id_i.
- Unmapped accesses are answered by an internal DECERR responder.
- Tracks outstanding transactions per direction so responses stay in order across target switches. It is the building block for per-initiator routing ahead of the cluster crossbar.

Parameters:
- NB_MST, 4, number of master ports (1..16)
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width
- AXI_ID_WIDTH, 4, ID width, unchanged slave to master
- AXI_USER_WIDTH, 6, user width
- BASE_ADDR, 64'h1000_0000, cluster 0 base
- CLUSTER_SHIFT, 22, cluster_id shift for base relocation
- WIN_OFFS, packed NB_MST x 64b, window start offsets relative to cluster base
- WIN_SIZE, packed NB_MST x 64b, window sizes in bytes; 0 disables the window
- MAX_TXNS, 8, max outstanding transactions per direction (power of 2)
- ERR_DATA, 64'hBADC_AB1E_BADC_AB1E, rdata returned on DECERR reads

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cluster_id_i  in  6  cluster index; must be static while busy_o=1
- slv  AXI_BUS.Slave  intf  upstream port
- mst  AXI_BUS.Master  intf[NB_MST]  downstream ports
- busy_o  out  1  any transaction outstanding in either direction
- decerr_cnt_o  out  16  saturating count of DECERR responses issued

Behaviour:
- Clocking and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- On reset:
  - all mst aw/w/ar valid = 0, slv aw/w/ar ready = 0, slv b/r valid = 0
  - counters and FIFO cleared, busy_o = 0, decerr_cnt_o = 0
  - error responder idle
- Decode:
  - base = BASE_ADDR + (cluster_id_i << CLUSTER_SHIFT), at AXI_ADDR_WIDTH.
  - Window i matches when base+WIN_OFFS[i] <= addr < base+WIN_OFFS[i]+WIN_SIZE[i].
  - Lowest matching index wins. No match selects the error target (index NB_MST).
  - Decode is combinational on aw/ar addr.
- Per direction, keep an outstanding counter (0..MAX_TXNS) and a current target.
- AW/AR accept rule: forward only when the counter is 0, or (target == current AND counter < MAX_TXNS). Otherwise stall with ready = 0 and no forwarding.
  - An AW/AR stalled on a target switch waits until the counter reaches 0; no reordering.
  - Valid, once presented to a master, is held with stable payload until that master's ready.
- Slave-side ready is the selected target's ready gated by the accept rule. Zero added latency; AW/AR pass combinationally.
- W routing:
  - Each accepted AW pushes its target into a MAX_TXNS-deep FIFO.
  - W beats go to the FIFO head target; the FIFO pops on the wlast handshake.
  - FIFO empty → slv.w_ready = 0.
  - A W beat may pass in the same cycle its AW is accepted (FIFO bypass).
- B path: muxed from the current write target. The write counter decrements on the slv B handshake.
- R path: muxed from the current read target. The read counter decrements on the rlast handshake.
- Increment and decrement in the same cycle → counter unchanged.
- Error responder, write side:
  - Accepts one AW, sinks W beats (w_ready = 1) until wlast.
  - Then the next cycle drives B with resp = 2'b11 and the echoed ID.
- Error responder, read side:
  - Accepts one AR, returns arlen+1 beats with rdata = ERR_DATA, resp = 2'b11, echoed ID.
  - rlast is asserted on the final beat; honours r_ready backpressure.
- Both error sides operate independently; each accepts a new request only when idle.
- decerr_cnt_o increments per DECERR B handshake and per DECERR read burst (on its rlast), and saturates at 16'hFFFF. A simultaneous B and R DECERR adds 2, saturating.
- busy_o = (wr counter != 0) | (rd counter != 0).
- Mid-operation reset: everything returns to the reset state immediately; in-flight transactions are dropped.

Test Plan:
- cluster_id = 3, WIN_OFFS[0] = 0, WIN_SIZE[0] = 0x10000; read at 0x10C0_0040 → routed to mst[0] only, data returned unchanged, busy_o 1 then 0.
- Overlapping windows 1 and 2 both covering 0x10C0_0200 → write goes to mst[1]; mst[2] sees no AW.
- Write len = 3 to unmapped 0x8000_0000 → 4 W beats sunk, B resp = 2'b11 with the ID echoed, decerr_cnt_o = 1. Read len = 7 unmapped → 8 beats of ERR_DATA, rlast on beat 8.
- MAX_TXNS = 8 reads issued to mst[0] with r held off → 9th AR stalls (ar_ready = 0) until the first rlast, then is accepted.
- Outstanding write to mst[0], then AW to mst[1] → AW stalls until mst[0]'s B handshakes, then forwards in the cycle the counter reaches 0. The W of the second write is never sent to mst[0].
- Reset asserted during a 4-beat error read after beat 2 → r_valid = 0 asynchronously, decerr_cnt_o = 0, busy_o = 0; a fresh read after release completes normally.
